// File: rtl/rr_bus_arbiter_if.sv
// Request/grant bundle between the bus masters (cores) and the round-robin arbiter.
interface rr_bus_arbiter_if #(
  parameter int unsigned NumOfRequesters = 4,
  parameter int unsigned IdxWidth        = (NumOfRequesters > 1) ? $clog2(NumOfRequesters) : 1
);
  logic [NumOfRequesters-1:0] req;
  logic [NumOfRequesters-1:0] done;
  logic [NumOfRequesters-1:0] access;
  logic                       busy;
  logic [IdxWidth-1:0]        owner;
  logic                       timeout;

  modport master (
    output req,
    output done,
    input  access,
    input  busy,
    input  owner,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output access,
    output busy,
    output owner,
    output timeout
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter with bounded tenure and one dead turnaround cycle between owners.
module rr_bus_arbiter #(
  parameter int unsigned NumOfRequesters = 4,
  parameter int unsigned MaxTenure       = 16,
  parameter int unsigned IdxWidth        = (NumOfRequesters > 1) ? $clog2(NumOfRequesters) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rr_bus_arbiter_if.slave bus
);

  localparam int unsigned CntWidth = (MaxTenure > 2) ? $clog2(MaxTenure) : 1;
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumOfRequesters - 1);
  localparam logic [CntWidth-1:0] CntLimit = CntWidth'(MaxTenure - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                     state_q, state_d;
  logic [IdxWidth-1:0]        ptr_q, ptr_d;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic [IdxWidth-1:0]        owner_q, owner_d;
  logic [NumOfRequesters-1:0] access_q, access_d;
  logic                       busy_q, busy_d;
  logic                       timeout_q, timeout_d;

  logic                win_found;
  logic [IdxWidth-1:0] win_idx;
  logic [IdxWidth-1:0] cand;
  int unsigned         sum;
  logic                own_req, own_done, release_own;

  // First requester at or after ptr_q, wrapping; ptr_q < N so one subtraction wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int unsigned i = 0; i < NumOfRequesters; i++) begin
      sum = 32'(ptr_q) + i;
      if (sum >= NumOfRequesters) sum = sum - NumOfRequesters;
      cand = IdxWidth'(sum);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign own_req     = bus.req[owner_q];
  assign own_done    = bus.done[owner_q];
  assign release_own = own_done | ~own_req | (cnt_q == CntLimit);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    access_d  = access_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          access_d          = '0;
          access_d[win_idx] = 1'b1;
          owner_d           = win_idx;
          cnt_d             = '0;
          busy_d            = 1'b1;
          state_d           = StGrant;
        end
      end
      StGrant: begin
        if (release_own) begin
          access_d  = '0;
          busy_d    = 1'b0;
          state_d   = StIdle;
          ptr_d     = (owner_q == LastIdx) ? '0 : owner_q + IdxWidth'(1);
          // Owner still wanted the bus and did not finish: only the tenure limit ended it.
          timeout_d = own_req & ~own_done;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      owner_q   <= '0;
      access_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      access_q  <= access_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.access  = access_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;
  assign bus.timeout = timeout_q;

endmodule
